// File: rtl/bias_add_stage.sv
// bias_add_stage
// Adds a per-group, per-lane signed bias to each accumulator vector leaving
// the adder trees and saturates every lane to DATA_W. Biases live in a small
// writable register file addressed as group*N_adder_tree + lane. A group
// pointer advances on every accepted vector so consecutive vectors pick up
// consecutive output-channel groups; start rewinds it at frame boundaries.
// One output register with valid/ready gives 1-cycle latency and full
// throughput when the downstream stage keeps out_ready_i high.

module bias_add_stage #(
  parameter int N_adder_tree = 16,
  parameter int DATA_W       = 18,
  parameter int N_GROUPS     = 4,
  parameter int ADDR_W       = $clog2(N_GROUPS * N_adder_tree),
  parameter int GRP_W        = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             cfg_we_i,
  input  logic [ADDR_W-1:0]                cfg_addr_i,
  input  logic [DATA_W-1:0]                cfg_data_i,
  input  logic                             start_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [N_adder_tree*DATA_W-1:0]   in_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [N_adder_tree*DATA_W-1:0]   out_data_o,
  output logic [GRP_W-1:0]                 out_group_o,
  output logic                             out_last_o,
  output logic                             ovf_o
);

  localparam int DEPTH = N_GROUPS * N_adder_tree;
  localparam int VEC_W = N_adder_tree * DATA_W;

  // When the address space is exactly filled no address can be out of range,
  // so the range compare is skipped to avoid a constant-true comparison.
  localparam bit              ADDR_FULL = (DEPTH == (1 << ADDR_W));
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  localparam logic [GRP_W-1:0]  GRP_LAST = GRP_W'(N_GROUPS - 1);
  localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  // Bias register file
  logic [DATA_W-1:0] bias_q [DEPTH];
  logic              cfg_addr_ok;

  // Group pointer and sticky overflow
  logic [GRP_W-1:0] grp_q, grp_d;
  logic             ovf_q, ovf_d;

  // Output register
  logic             out_valid_q, out_valid_d;
  logic [VEC_W-1:0] out_data_q, out_data_d;
  logic [GRP_W-1:0] out_group_q, out_group_d;
  logic             out_last_q, out_last_d;

  // Datapath
  logic                     accept;
  logic [GRP_W-1:0]         grp_use;
  logic [VEC_W-1:0]         sum_vec;
  logic [N_adder_tree-1:0]  lane_sat;
  logic                     any_sat;
  logic [ADDR_W-1:0]        rd_idx;
  logic [DATA_W-1:0]        lane_a;
  logic [DATA_W-1:0]        lane_b;
  logic [DATA_W:0]          lane_sum;
  logic [DATA_W-1:0]        lane_res;

  assign cfg_addr_ok = ADDR_FULL ? 1'b1 : ({1'b0, cfg_addr_i} < DEPTH_L);

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  // A vector accepted together with start belongs to the new frame: group 0.
  assign grp_use = start_i ? '0 : grp_q;

  // Bias writes; a same-edge read in the adder still sees the old word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        bias_q[k] <= '0;
      end
    end else if (cfg_we_i && cfg_addr_ok) begin
      bias_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  // Per-lane sign-extended add with clamp to the DATA_W signed range.
  always_comb begin
    sum_vec  = '0;
    lane_sat = '0;
    rd_idx   = '0;
    lane_a   = '0;
    lane_b   = '0;
    lane_sum = '0;
    lane_res = '0;
    for (int i = 0; i < N_adder_tree; i++) begin
      rd_idx   = ADDR_W'(int'(grp_use) * N_adder_tree + i);
      lane_a   = in_data_i[i*DATA_W +: DATA_W];
      lane_b   = bias_q[rd_idx];
      lane_sum = {lane_a[DATA_W-1], lane_a} + {lane_b[DATA_W-1], lane_b};
      // The two top bits disagree exactly when the sum left the DATA_W range;
      // the extra top bit then carries the true sign.
      if (lane_sum[DATA_W] != lane_sum[DATA_W-1]) begin
        lane_sat[i] = 1'b1;
        lane_res    = lane_sum[DATA_W] ? SAT_MIN : SAT_MAX;
      end else begin
        lane_res    = lane_sum[DATA_W-1:0];
      end
      sum_vec[i*DATA_W +: DATA_W] = lane_res;
    end
  end

  assign any_sat = |lane_sat;

  // Next-state for group pointer, overflow flag and output register.
  always_comb begin
    grp_d       = grp_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_group_d = out_group_q;
    out_last_d  = out_last_q;

    if (accept) begin
      grp_d = (grp_use == GRP_LAST) ? '0 : grp_use + 1'b1;
    end else if (start_i) begin
      grp_d = '0;
    end

    // Saturation in the same cycle as start must survive the clear.
    if (accept && any_sat) begin
      ovf_d = 1'b1;
    end else if (start_i) begin
      ovf_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sum_vec;
      out_group_d = grp_use;
      out_last_d  = (grp_use == GRP_LAST);
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any in-flight output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grp_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_group_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      grp_q       <= grp_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_group_q <= out_group_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_group_o = out_group_q;
  assign out_last_o  = out_last_q;
  assign ovf_o       = ovf_q;

endmodule

// File: doc/bias_add_stage.md
# bias_add_stage

Programmable bias-add stage for SqueezeNext conv layers, replacing per-layer hard-coded bias constant banks. Holds N_GROUPS × N_adder_tree signed bias words in a writable register file. Adds the bias vector of the current output-channel group to each accumulator vector leaving the adder trees, saturating to DATA_W. Sits between the adder-tree outputs and the activation/requantisation stage, with valid/ready on both sides.

## Interface
- N_adder_tree, 16, lanes per vector (one bias word per lane)
- DATA_W, 18, signed two's-complement width of biases, inputs and outputs
- N_GROUPS, 4, bias groups per layer (output channels / N_adder_tree), ≥2
- ADDR_W, clog2(N_GROUPS*N_adder_tree), config address width (derived)
- GRP_W, max(1,clog2(N_GROUPS)), group index width (derived)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_we  in  1  bias write strobe
- cfg_addr  in  ADDR_W  word address = group*N_adder_tree + lane
- cfg_data  in  DATA_W  bias word
- start  in  1  single-cycle frame start; rewinds group pointer, clears ovf
- in_valid  in  1  accumulator vector valid
- in_ready  out  1  stage can accept
- in_data  in  N_adder_tree*DATA_W  lane i at [DATA_W*(i+1)-1 : DATA_W*i]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  N_adder_tree*DATA_W  biased, saturated lanes, same packing
- out_group  out  GRP_W  group index used for out_data
- out_last  out  1  out_group == N_GROUPS-1
- ovf  out  1  sticky: any lane saturated since reset/start

## Operation
- Register file: N_GROUPS*N_adder_tree words. cfg_we=1 writes cfg_data at cfg_addr on the edge. Out-of-range cfg_addr ignored. Writes allowed at any time.
- Group pointer grp (GRP_W bits):
  - On each accepted input (in_valid & in_ready): grp ← grp+1, wrapping N_GROUPS-1 → 0.
  - start=1 forces grp ← 0, or 1 if an input is accepted in the same cycle. That input uses group 0.
- Add, per lane: sum = sext(in_lane) + sext(bias[grp][lane]), DATA_W+1 bits.
  - Sum > 2^(DATA_W-1)-1 → 2^(DATA_W-1)-1 (18'h1FFFF).
  - Sum < -2^(DATA_W-1) → -2^(DATA_W-1) (18'h20000).
  - Otherwise low DATA_W bits.
  - Any clamped lane in an accepted vector sets ovf.
- Bias read/write collision: the add uses the register value before the edge. A same-cycle cfg write to that word affects only later vectors.
- Output register:
  - in_ready = !out_valid | out_ready.
  - On acceptance, out_data/out_group/out_last load and out_valid ← 1.
  - Else if out_ready, out_valid ← 0.
  - out_data, out_group and out_last are held stable while out_valid & !out_ready.
- ovf: cleared by start. If start and a saturating accept occur in the same cycle, set wins.

## Timing
- Latency: 1 cycle from input acceptance to out_valid.
- Throughput: 1 vector/cycle when out_ready=1.
- Reset (async, immediate), all zero: out_valid, out_data, out_group, out_last, ovf, grp, all bias words. in_ready=1 after reset.
- Reset mid-stream: the in-flight output is discarded and biases are lost. Software reloads biases after reset.
- start does not flush the output register; a pending output keeps its original group.
- cfg write to word k at edge t is used by any vector accepted at edge t+1 or later.

## Test plan
- Reset: assert rst mid-transfer → out_valid=0, ovf=0, in_ready=1 immediately. After release, vector of all 5 with no cfg → out_data all 5, out_group=0.
- Basic add, N_GROUPS=4: load bias[g][i]=g*100+i. Send 4 vectors of lane value 1000 → group g lane i = 1000+g*100+i, out_group 0..3, out_last only on the 4th. The 5th vector uses group 0 (wrap).
- Saturation:
  - lane 0x1FF00 + bias 0x00200 → 0x1FFFF.
  - lane 0x20100 + bias -0x200 (0x3FE00) → 0x20000.
  - ovf=1 after the first case; start clears it.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 after the first accept, out_data stable, grp advanced once. Release → next vector uses the next group, no drop or duplicate.
- start mid-frame: after 2 accepts (grp=2), start with a simultaneous accept → that vector uses group 0, next uses group 1.
- Collision: cfg write bias[0][0]=50 (was 10) in the same cycle as a group-0 accept of lane value 0 → result 10. Next group-0 vector → 50.
